// File: rtl/opcodes.sv
// rtl/opcodes.sv - shared opcode, ALU, PC-select and controller-state types
// Purpose: type definitions shared by the accumulator datapath and its controllers.
// Ports: none (package).
package opcodes;

  typedef enum logic [3:0] {
    NOOP  = 4'd0,
    WAIT0 = 4'd1,
    WAIT1 = 4'd2,
    STSW  = 4'd3,
    STACC = 4'd4,
    PASSA = 4'd5,
    ADD   = 4'd6,
    LUI   = 4'd7,
    ADDI  = 4'd8,
    JMPA  = 4'd9,
    JMPI  = 4'd10,
    MULT  = 4'd11
  } opcodes_t;

  typedef enum logic [1:0] {
    ALU_NOOP = 2'd0,
    ALU_A    = 2'd1,
    ALU_ADD  = 2'd2,
    ALU_MULT = 2'd3
  } alu_functions_t;

  typedef enum logic [1:0] {
    PcWait = 2'd0,
    PcInc  = 2'd1,
    PcJmp  = 2'd2
  } PcSel_t;

  typedef enum logic [1:0] {
    Fetch    = 2'd0,
    Read     = 2'd1,
    Execute  = 2'd2,
    MultWait = 2'd3
  } ctrl_state_t;

  localparam int MULT_CNT_W = 4;

endpackage

// File: rtl/control_mc_if.sv
// rtl/control_mc_if.sv - fetch handshake and instruction fields between IR/imem and controller
// Purpose: bundles the instruction-fetch handshake with the decoded IR fields.
// Ports (signals): InstrReq, IrLoad (controller -> imem/IR); InstrReady, OpCode, SwSel (imem/IR -> controller).
// Modports: master = controller side, slave = instruction memory / IR side.
interface control_mc_if #(
  parameter int SEL_W = 3
);

  logic              InstrReq;
  logic              InstrReady;
  logic              IrLoad;
  opcodes::opcodes_t OpCode;
  logic [SEL_W-1:0]  SwSel;

  modport master (
    output InstrReq,
    output IrLoad,
    input  InstrReady,
    input  OpCode,
    input  SwSel
  );

  modport slave (
    input  InstrReq,
    input  IrLoad,
    output InstrReady,
    output OpCode,
    output SwSel
  );

endinterface

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - cycle counter pacing the iterative multiplier
// Purpose: loads MULT_CYCLES-2 on MultStart, counts down to 0 and holds there.
// Ports: Clock, Reset (async, active-high), MultStart (load strobe), Done (count is 0).
module mult_sequencer
  import opcodes::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic MultStart,
  output logic Done
);

  // Execute consumes one cycle and the exit MultWait cycle another, so the
  // count covers only the cycles in between.
  localparam int LOAD_INT = (MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0;
  localparam logic [MULT_CNT_W-1:0] LOAD = LOAD_INT[MULT_CNT_W-1:0];

  logic [MULT_CNT_W-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (MultStart) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign Done = (count == '0);

endmodule

// File: rtl/control_mc.sv
// rtl/control_mc.sv - multi-cycle instruction-sequencing controller for the accumulator datapath
// Purpose: Fetch/Read/Execute/MultWait sequencing with stallable fetch, iterative MULT
//          and WAIT instructions on a run-time-selected switch bit.
// Ports: Clock, Reset (async, active-high); Sw switch inputs; fetch (control_mc_if.master:
//        InstrReq, IrLoad, InstrReady, OpCode, SwSel); MultStart strobe; datapath controls
//        RegWe, WDataSel, AccStore, Op1Sel, ImmSel, Op2Sel, AluOp, PcSel; Busy.
module control_mc
  import opcodes::*;
#(
  parameter int SW_WIDTH    = 8,
  parameter int SEL_W       = $clog2(SW_WIDTH),
  parameter int MULT_CYCLES = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [SW_WIDTH-1:0] Sw,
  control_mc_if.master        fetch,
  output logic                MultStart,
  output logic                RegWe,
  output logic                WDataSel,
  output logic                AccStore,
  output logic                Op1Sel,
  output logic                ImmSel,
  output logic                Op2Sel,
  output alu_functions_t      AluOp,
  output PcSel_t              PcSel,
  output logic                Busy
);

  ctrl_state_t state, nextState;
  logic        multDone;
  logic        multStart;
  logic        instrReq;
  logic        irLoad;
  logic        swBit;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= Fetch;
    end else begin
      state <= nextState;
    end
  end

  mult_sequencer #(
    .MULT_CYCLES(MULT_CYCLES)
  ) u_mult_sequencer (
    .Clock    (Clock),
    .Reset    (Reset),
    .MultStart(multStart),
    .Done     (multDone)
  );

  // Select outside the implemented switch range reads as 0.
  always_comb begin
    swBit = 1'b0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      if (fetch.SwSel == i[SEL_W-1:0]) swBit = Sw[i];
    end
  end

  always_comb begin
    nextState = state;
    instrReq  = 1'b0;
    irLoad    = 1'b0;
    multStart = 1'b0;
    RegWe     = 1'b0;
    WDataSel  = 1'b0;
    AccStore  = 1'b0;
    Op1Sel    = 1'b0;
    ImmSel    = 1'b0;
    Op2Sel    = 1'b0;
    AluOp     = ALU_NOOP;
    PcSel     = PcWait;
    // Reset forces Fetch asynchronously; gating here keeps the Fetch
    // request and IR strobe quiet while reset is still held.
    if (!Reset) begin
      unique case (state)
        Fetch: begin
          instrReq = 1'b1;
          if (fetch.InstrReady) begin
            irLoad    = 1'b1;
            nextState = Read;
          end
        end
        Read: nextState = Execute;
        Execute: begin
          PcSel     = PcInc;
          nextState = Fetch;
          case (fetch.OpCode)
            WAIT0: if (!swBit) PcSel = PcWait;
            WAIT1: if (swBit) PcSel = PcWait;
            STSW: begin
              WDataSel = 1'b1;
              RegWe    = 1'b1;
            end
            STACC: RegWe = 1'b1;
            PASSA: begin
              AluOp    = ALU_A;
              AccStore = 1'b1;
            end
            ADD: begin
              AluOp    = ALU_ADD;
              AccStore = 1'b1;
            end
            LUI: begin
              Op1Sel   = 1'b1;
              ImmSel   = 1'b1;
              AluOp    = ALU_A;
              AccStore = 1'b1;
            end
            ADDI: begin
              Op1Sel   = 1'b1;
              AluOp    = ALU_ADD;
              AccStore = 1'b1;
            end
            JMPA: begin
              Op1Sel = 1'b1;
              AluOp  = ALU_ADD;
              PcSel  = PcJmp;
            end
            JMPI: begin
              Op1Sel = 1'b1;
              Op2Sel = 1'b1;
              AluOp  = ALU_ADD;
              PcSel  = PcJmp;
            end
            MULT: begin
              AluOp = ALU_MULT;
              if (MULT_CYCLES == 1) begin
                AccStore = 1'b1;
              end else begin
                multStart = 1'b1;
                PcSel     = PcWait;
                nextState = MultWait;
              end
            end
            default: ;
          endcase
        end
        MultWait: begin
          AluOp = ALU_MULT;
          if (multDone) begin
            AccStore  = 1'b1;
            PcSel     = PcInc;
            nextState = Fetch;
          end
        end
        default: nextState = Fetch;
      endcase
    end
  end

  assign fetch.InstrReq = instrReq;
  assign fetch.IrLoad   = irLoad;
  assign MultStart      = multStart;
  assign Busy           = (state != Fetch);

endmodule

// File: tb/tb_control_mc.sv
// tb/tb_control_mc.sv - directed-vector bench for control_mc
module tb_control_mc;
  import opcodes::*;

  logic     Clock = 1'b0;
  logic     Reset = 1'b1;
  logic     instrReady;
  opcodes_t opCode;
  logic [2:0] swSel;
  logic [7:0] sw8;
  logic [5:0] sw6;

  int vecCount  = 0;
  int missCount = 0;

  always #5 Clock = ~Clock;

  // Instance 0: SW_WIDTH=8, MULT_CYCLES=4; 1: MULT_CYCLES=1; 2: SW_WIDTH=6.
  control_mc_if #(.SEL_W(3)) fA ();
  control_mc_if #(.SEL_W(3)) fB ();
  control_mc_if #(.SEL_W(3)) fC ();

  assign fA.InstrReady = instrReady;
  assign fB.InstrReady = instrReady;
  assign fC.InstrReady = instrReady;
  assign fA.OpCode = opCode;
  assign fB.OpCode = opCode;
  assign fC.OpCode = opCode;
  assign fA.SwSel = swSel;
  assign fB.SwSel = swSel;
  assign fC.SwSel = swSel;

  logic [2:0] instrReq, irLoad, multStart, regWe, wDataSel, accStore;
  logic [2:0] op1Sel, immSel, op2Sel, busy;
  alu_functions_t aluOp [3];
  PcSel_t         pcSel [3];

  assign instrReq[0] = fA.InstrReq;
  assign instrReq[1] = fB.InstrReq;
  assign instrReq[2] = fC.InstrReq;
  assign irLoad[0] = fA.IrLoad;
  assign irLoad[1] = fB.IrLoad;
  assign irLoad[2] = fC.IrLoad;

  control_mc #(.SW_WIDTH(8), .MULT_CYCLES(4)) dutA (
    .Clock(Clock), .Reset(Reset), .Sw(sw8), .fetch(fA),
    .MultStart(multStart[0]), .RegWe(regWe[0]), .WDataSel(wDataSel[0]),
    .AccStore(accStore[0]), .Op1Sel(op1Sel[0]), .ImmSel(immSel[0]),
    .Op2Sel(op2Sel[0]), .AluOp(aluOp[0]), .PcSel(pcSel[0]), .Busy(busy[0])
  );

  control_mc #(.SW_WIDTH(8), .MULT_CYCLES(1)) dutB (
    .Clock(Clock), .Reset(Reset), .Sw(sw8), .fetch(fB),
    .MultStart(multStart[1]), .RegWe(regWe[1]), .WDataSel(wDataSel[1]),
    .AccStore(accStore[1]), .Op1Sel(op1Sel[1]), .ImmSel(immSel[1]),
    .Op2Sel(op2Sel[1]), .AluOp(aluOp[1]), .PcSel(pcSel[1]), .Busy(busy[1])
  );

  control_mc #(.SW_WIDTH(6), .MULT_CYCLES(4)) dutC (
    .Clock(Clock), .Reset(Reset), .Sw(sw6), .fetch(fC),
    .MultStart(multStart[2]), .RegWe(regWe[2]), .WDataSel(wDataSel[2]),
    .AccStore(accStore[2]), .Op1Sel(op1Sel[2]), .ImmSel(immSel[2]),
    .Op2Sel(op2Sel[2]), .AluOp(aluOp[2]), .PcSel(pcSel[2]), .Busy(busy[2])
  );

  // {InstrReq, IrLoad, MultStart, RegWe, WDataSel, AccStore, Op1Sel, ImmSel, Op2Sel, Busy, AluOp, PcSel}
  function automatic logic [13:0] mk(input logic req, ir, ms, we, wds, acc, o1, imm, o2, bsy,
                                     input alu_functions_t alu, input PcSel_t pc);
    return {req, ir, ms, we, wds, acc, o1, imm, o2, bsy, alu, pc};
  endfunction

  function automatic logic [13:0] obs(input int k);
    return {instrReq[k], irLoad[k], multStart[k], regWe[k], wDataSel[k], accStore[k],
            op1Sel[k], immSel[k], op2Sel[k], busy[k], aluOp[k], pcSel[k]};
  endfunction

  logic [13:0] fIr, fStall, rd, idle;

  task automatic chkVec(input string tag, input logic [13:0] got, input logic [13:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  // One Fetch/Read/Execute pass on instance 0, optional PcSel check on instance 2.
  task automatic doInstr(input string tag, input opcodes_t op, input logic [2:0] sel,
                         input logic [13:0] expExe, input int expPcC);
    opCode = op;
    swSel = sel;
    instrReady = 1'b1;
    #3 chkVec({tag, "_fetch"}, obs(0), fIr);
    nextCycle();
    #3 chkVec({tag, "_read"}, obs(0), rd);
    nextCycle();
    #3 chkVec({tag, "_exec"}, obs(0), expExe);
    if (expPcC >= 0) chkVec({tag, "_execC"}, {12'b0, pcSel[2]}, expPcC[13:0]);
    nextCycle();
  endtask

  // Full MULT on instance 0; optionally instance 1 alongside (single-cycle MULT, refetches).
  task automatic multA(input string tag, input logic checkB);
    logic [13:0] expA [6];
    logic [13:0] expB [6];
    logic [13:0] bExe;
    bExe = mk(0,0,0,0,0,1,0,0,0,1,ALU_MULT,PcInc);
    expA[0] = fIr;
    expA[1] = rd;
    expA[2] = mk(0,0,1,0,0,0,0,0,0,1,ALU_MULT,PcWait);
    expA[3] = mk(0,0,0,0,0,0,0,0,0,1,ALU_MULT,PcWait);
    expA[4] = expA[3];
    expA[5] = mk(0,0,0,0,0,1,0,0,0,1,ALU_MULT,PcInc);
    expB[0] = fIr;
    expB[1] = rd;
    expB[2] = bExe;
    expB[3] = fIr;
    expB[4] = rd;
    expB[5] = bExe;
    opCode = MULT;
    instrReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3 chkVec($sformatf("%s_a%0d", tag, c), obs(0), expA[c]);
      if (checkB) chkVec($sformatf("%s_b%0d", tag, c), obs(1), expB[c]);
      nextCycle();
    end
  endtask

  initial begin
    logic [13:0] eAdd, eWait, eInc;
    fIr    = mk(1,1,0,0,0,0,0,0,0,0,ALU_NOOP,PcWait);
    fStall = mk(1,0,0,0,0,0,0,0,0,0,ALU_NOOP,PcWait);
    rd     = mk(0,0,0,0,0,0,0,0,0,1,ALU_NOOP,PcWait);
    idle   = 14'h0;
    eAdd   = mk(0,0,0,0,0,1,0,0,0,1,ALU_ADD,PcInc);
    eWait  = mk(0,0,0,0,0,0,0,0,0,1,ALU_NOOP,PcWait);
    eInc   = mk(0,0,0,0,0,0,0,0,0,1,ALU_NOOP,PcInc);

    Reset = 1'b1;
    instrReady = 1'b1;
    opCode = ADD;
    swSel = 3'd0;
    sw8 = 8'h00;
    sw6 = 6'h00;
    nextCycle();
    #3;
    chkVec("reset_a", obs(0), idle);
    chkVec("reset_b", obs(1), idle);
    chkVec("reset_c", obs(2), idle);
    nextCycle();
    Reset = 1'b0;

    for (int i = 0; i < 3; i++) doInstr($sformatf("add%0d", i), ADD, 3'd0, eAdd, -1);

    instrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3 chkVec($sformatf("stall%0d", i), obs(0), fStall);
      nextCycle();
    end
    doInstr("stall_go", ADD, 3'd0, eAdd, -1);

    doInstr("stsw",  STSW,  3'd0, mk(0,0,0,1,1,0,0,0,0,1,ALU_NOOP,PcInc), -1);
    doInstr("stacc", STACC, 3'd0, mk(0,0,0,1,0,0,0,0,0,1,ALU_NOOP,PcInc), -1);
    doInstr("passa", PASSA, 3'd0, mk(0,0,0,0,0,1,0,0,0,1,ALU_A,PcInc), -1);
    doInstr("lui",   LUI,   3'd0, mk(0,0,0,0,0,1,1,1,0,1,ALU_A,PcInc), -1);
    doInstr("addi",  ADDI,  3'd0, mk(0,0,0,0,0,1,1,0,0,1,ALU_ADD,PcInc), -1);
    doInstr("noop",  NOOP,  3'd0, eInc, -1);
    doInstr("unkn",  opcodes_t'(4'd15), 3'd0, eInc, -1);
    doInstr("jmpi",  JMPI,  3'd0, mk(0,0,0,0,0,0,1,0,1,1,ALU_ADD,PcJmp), -1);
    doInstr("jmpa",  JMPA,  3'd0, mk(0,0,0,0,0,0,1,0,0,1,ALU_ADD,PcJmp), -1);

    sw8 = 8'h20;
    doInstr("wait1_hold0", WAIT1, 3'd5, eWait, -1);
    doInstr("wait1_hold1", WAIT1, 3'd5, eWait, -1);
    doInstr("wait0_go",    WAIT0, 3'd5, eInc, -1);
    sw8 = 8'h00;
    doInstr("wait1_go",    WAIT1, 3'd5, eInc, -1);
    doInstr("wait0_hold",  WAIT0, 3'd5, eWait, -1);
    sw8 = 8'hFF;
    sw6 = 6'h3F;
    doInstr("sel7_wait0", WAIT0, 3'd7, eInc, int'(PcWait));
    doInstr("sel7_wait1", WAIT1, 3'd7, eWait, int'(PcInc));

    multA("mult", 1'b1);

    opCode = MULT;
    instrReady = 1'b1;
    #3 chkVec("mrst_fetch", obs(0), fIr);
    nextCycle();
    #3 chkVec("mrst_read", obs(0), rd);
    nextCycle();
    #3 chkVec("mrst_exec", obs(0), mk(0,0,1,0,0,0,0,0,0,1,ALU_MULT,PcWait));
    nextCycle();
    #3 chkVec("mrst_mw1", obs(0), mk(0,0,0,0,0,0,0,0,0,1,ALU_MULT,PcWait));
    nextCycle();
    Reset = 1'b1;
    #3 chkVec("mrst_asserted", obs(0), idle);
    nextCycle();
    #3 chkVec("mrst_held", obs(0), idle);
    nextCycle();
    Reset = 1'b0;
    multA("mult_after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/control_mc.md
Name: control_mc

Overview:
Multi-cycle instruction-sequencing controller for the accumulator datapath. It is the parametrised successor of the fixed three-phase controller.
- Adds a fetch handshake with instruction memory, so fetch can stall.
- Adds an iterative multi-cycle MULT with a parametrised latency.
- Adds WAIT instructions that test a run-time-selected switch bit instead of a fixed one.
- Drives the same datapath selects (register write, write-data select, accumulator store, operand selects, ALU op, PC select), plus fetch and multiplier-control strobes.

Parameters:
SW_WIDTH, 8, number of switch inputs WAIT instructions may test
SEL_W, $clog2(SW_WIDTH), width of the switch-select field
MULT_CYCLES, 4, cycles the multiplier needs (1..16); 1 gives single-cycle MULT

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
OpCode  in  opcodes::opcodes_t  decoded instruction opcode, valid from Read onward
SwSel  in  SEL_W  instruction field selecting which switch bit WAIT0/WAIT1 test
Sw  in  SW_WIDTH  switch inputs, synchronised externally
InstrReady  in  1  instruction memory has data for the current request
InstrReq  out  1  fetch request to instruction memory
IrLoad  out  1  one-cycle strobe: capture instruction into IR
MultStart  out  1  one-cycle strobe: start the iterative multiplier
RegWe, WDataSel, AccStore, Op1Sel, ImmSel, Op2Sel  out  1 each  datapath controls, same meaning as the existing controller
AluOp  out  opcodes::alu_functions_t  ALU function
PcSel  out  opcodes::PcSel_t  PC next-value select
Busy  out  1  high in every state except Fetch

Behaviour:
- State machine (ctrl_state_t): Fetch, Read, Execute, MultWait. Reset value is Fetch; the multiplier counter resets to 0.
- While Reset is high, all outputs take their defaults: 0, ALU_NOOP, PcWait, InstrReq=0.
- Defaults in every state: RegWe=WDataSel=AccStore=Op1Sel=ImmSel=Op2Sel=0, AluOp=ALU_NOOP, PcSel=PcWait, MultStart=IrLoad=0.
- Fetch:
  - InstrReq=1.
  - If InstrReady=1: IrLoad=1, next state Read.
  - Otherwise remain in Fetch, with no cycle limit.
- Read: one cycle, then Execute.
- Execute: PcSel=PcInc unless overridden below; next state Fetch except for MULT.
  - NOOP and unknown opcodes: defaults plus PcInc.
  - WAIT0: PcSel=PcWait when Sw[SwSel]=0. WAIT1: PcSel=PcWait when Sw[SwSel]=1.
  - If SwSel>=SW_WIDTH, the tested bit reads as 0.
  - A waiting instruction returns to Fetch and is refetched from the unchanged PC.
  - STSW: WDataSel=1, RegWe=1.
  - STACC: RegWe=1.
  - PASSA: AluOp=ALU_A, AccStore=1.
  - ADD: AluOp=ALU_ADD, AccStore=1.
  - LUI: Op1Sel=1, ImmSel=1, AluOp=ALU_A, AccStore=1.
  - ADDI: Op1Sel=1, AluOp=ALU_ADD, AccStore=1.
  - JMPA: Op1Sel=1, Op2Sel=0, AluOp=ALU_ADD, PcSel=PcJmp.
  - JMPI: Op1Sel=1, Op2Sel=1, AluOp=ALU_ADD, PcSel=PcJmp.
  - MULT with MULT_CYCLES=1: AluOp=ALU_MULT, AccStore=1, PcInc, next state Fetch.
  - MULT with MULT_CYCLES>1: MultStart=1, AluOp=ALU_MULT, PcSel=PcWait, counter loads MULT_CYCLES-2, next state MultWait.
- MultWait:
  - AluOp=ALU_MULT held throughout; PcSel=PcWait.
  - If counter!=0: decrement and stay.
  - If counter==0: AccStore=1, PcSel=PcInc, next state Fetch.
  - Total MULT Execute+MultWait length is exactly MULT_CYCLES cycles.
- Counter width is 4 bits. It saturates at 0 and never wraps.
- OpCode and SwSel are sampled combinationally. They must stay stable from IrLoad until the next Fetch; the IR guarantees this.
- Reset asserted mid-MultWait or mid-Fetch:
  - Immediate return to Fetch with counter=0.
  - No AccStore or RegWe is emitted.
- InstrReady high outside Fetch is ignored.
- Busy = (state != Fetch); Busy is 0 during reset.

Decomposition:
- opcodes package gains ctrl_state_t (enum logic [1:0]: Fetch, Read, Execute, MultWait).
- opcodes package gains MULT_CNT_W=4.
- Existing opcodes_t, alu_functions_t and PcSel_t are reused unchanged.
- One sub-module: mult_sequencer.
  - Contents: the counter, load on MultStart, and a done flag when the count reaches 0.
  - control_mc instantiates it and uses done for the MultWait exit.
- Decode stays in a single always_comb block inside control_mc.

Test Plan:
- Reset, then InstrReady=1 constantly with OpCode=ADD -> repeating 3-cycle pattern: InstrReq/IrLoad, Read, Execute with AccStore=1, AluOp=ALU_ADD, PcSel=PcInc.
- InstrReady held 0 for 5 cycles then 1 -> InstrReq high 6 cycles, IrLoad exactly once on the 6th, Busy=0 throughout the stall.
- MULT_CYCLES=4, OpCode=MULT -> MultStart on the Execute cycle, AccStore=1 and PcInc exactly 3 cycles later; MULT_CYCLES=1 build -> AccStore in Execute, MultStart never asserted.
- WAIT1, SwSel=5, Sw=8'h20 -> PcWait each Execute; Sw=8'h00 -> PcInc; SW_WIDTH=6, SwSel=7 -> bit reads 0, so WAIT0 waits and WAIT1 proceeds.
- Reset asserted 2 cycles into MultWait -> state Fetch immediately, no AccStore pulse, next MULT again takes the full 4 cycles.
- JMPI then JMPA -> Op1Sel=1, Op2Sel=1 then 0, AluOp=ALU_ADD, PcSel=PcJmp in Execute only.
